// File: rtl/serial_adder.sv
// Bit-serial adder: one full-add cell and a registered carry,
// LSB first, one bit pair per clock, {cout,sum} on a done strobe.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] ps;
  logic             carry;
  logic [CW-1:0]    count;

  logic             s;
  logic             c_nx;
  logic [WIDTH:0]   ps_ext;
  logic [WIDTH-1:0] ps_nx;
  logic             last;

  assign s      = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_nx   = (a_sh[0] & b_sh[0])
                | (a_sh[0] & carry)
                | (b_sh[0] & carry);
  // Widened concat keeps the shift legal when WIDTH is 1.
  assign ps_ext = {s, ps};
  assign ps_nx  = ps_ext[WIDTH:1];
  assign last   = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      ps    <= '0;
      carry <= 1'b0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            ps    <= '0;
            carry <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= c_nx;
          ps    <= ps_nx;
          count <= count + CW'(1);
          if (last) begin
            sum   <= ps_nx;
            cout  <= c_nx;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
